// File: rtl/ram_byte_ctrl.sv
// ram_byte_ctrl: serves the data cache's 32-bit RAM request port from an
// 8-bit synchronous external RAM. Each word read becomes four byte reads
// and each word write becomes byte writes gated by the byte enables.
// Little-endian: byte 0 is data[7:0] at the lowest byte address.
//
// Optional build macro RAM_BYTE_CTRL_WRITE_SKIP_EN: when defined, writes visit
// only enabled bytes (one cycle each, strobe on every write cycle), and a
// write with no enabled bytes completes without any RAM cycle. When undefined,
// every write takes four RAM cycles with the strobe gated by the byte enable.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_addr_i    word request address (bits [1:0] and above RAM_ADDR_W ignored)
//   req_we_i      1 = write, 0 = read
//   req_sel_i     write byte enables, sel[i] enables byte i
//   req_data_i    write data
//   req_ce_i      request valid, held until req_ready_o
//   req_data_o    read data, updated only by a completed read
//   req_ready_o   one-cycle completion pulse
//   busy_o        high whenever the controller is not idle
//   ram_a_o       external byte address (holds when idle)
//   ram_wr_o      external byte write strobe
//   ram_dout_o    external byte write data (holds when idle)
//   ram_din_i     external byte read data, one cycle after its address
module ram_byte_ctrl #(
  parameter int unsigned RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           req_addr_i,
  input  logic                  req_we_i,
  input  logic [3:0]            req_sel_i,
  input  logic [31:0]           req_data_i,
  input  logic                  req_ce_i,
  output logic [31:0]           req_data_o,
  output logic                  req_ready_o,
  output logic                  busy_o,
  output logic [RAM_ADDR_W-1:0] ram_a_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                  state_q;
  logic [2:0]              cnt_q;
  logic [RAM_ADDR_W-1:2]   base_q;
  logic [3:0]              sel_q;
  logic [31:0]             data_q;
  logic [23:0]             rbuf_q;
  logic [31:0]             req_data_q;
  logic                    ready_q;
  logic [RAM_ADDR_W-1:0]   ram_a_q;
  logic                    ram_wr_q;
  logic [7:0]              ram_dout_q;

  // Byte index following the current one (wraps only where unused).
  logic [1:0]              nidx;
  assign nidx = cnt_q[1:0] + 2'd1;

  // Address bits outside the byte-address window are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr_i[31:RAM_ADDR_W], req_addr_i[1:0]};

`ifdef RAM_BYTE_CTRL_WRITE_SKIP_EN
  // Lowest enabled byte index at or above 'from'; 4 means none left.
  function automatic logic [2:0] next_sel(input logic [3:0] sel,
                                          input logic [2:0] from);
    next_sel = 3'd4;
    for (int unsigned i = 4; i > 0; i--) begin
      if ((i - 1) >= from && sel[i-1]) next_sel = 3'(i - 1);
    end
  endfunction

  logic [2:0] first_idx;
  logic [2:0] next_idx;
  always_comb begin
    first_idx = next_sel(req_sel_i, 3'd0);
    next_idx  = next_sel(sel_q, cnt_q + 3'd1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      rbuf_q     <= '0;
      req_data_q <= '0;
      ready_q    <= 1'b0;
      ram_a_q    <= '0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= '0;
    end else begin
      ready_q  <= 1'b0;
      ram_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_ce_i) begin
            base_q <= req_addr_i[RAM_ADDR_W-1:2];
            sel_q  <= req_sel_i;
            data_q <= req_data_i;
            cnt_q  <= '0;
            if (!req_we_i) begin
              state_q <= READ;
              ram_a_q <= {req_addr_i[RAM_ADDR_W-1:2], 2'b00};
            end else begin
`ifdef RAM_BYTE_CTRL_WRITE_SKIP_EN
              if (first_idx[2]) begin
                state_q <= DONE;
                ready_q <= 1'b1;
              end else begin
                state_q    <= WRITE;
                cnt_q      <= first_idx;
                ram_a_q    <= {req_addr_i[RAM_ADDR_W-1:2], first_idx[1:0]};
                ram_dout_q <= req_data_i[{first_idx[1:0], 3'b000} +: 8];
                ram_wr_q   <= 1'b1;
              end
`else
              state_q    <= WRITE;
              ram_a_q    <= {req_addr_i[RAM_ADDR_W-1:2], 2'b00};
              ram_dout_q <= req_data_i[7:0];
              ram_wr_q   <= req_sel_i[0];
`endif
            end
          end
        end

        // Address for byte n goes out at cnt=n; its data arrives at cnt=n+1.
        READ: begin
          case (cnt_q)
            3'd1:    rbuf_q[7:0]   <= ram_din_i;
            3'd2:    rbuf_q[15:8]  <= ram_din_i;
            3'd3:    rbuf_q[23:16] <= ram_din_i;
            default: ;
          endcase
          if (cnt_q == 3'd4) begin
            req_data_q <= {ram_din_i, rbuf_q};
            ready_q    <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q != 3'd3) ram_a_q <= {base_q, nidx};
          end
        end

        WRITE: begin
`ifdef RAM_BYTE_CTRL_WRITE_SKIP_EN
          if (next_idx[2]) begin
            state_q <= DONE;
            ready_q <= 1'b1;
          end else begin
            cnt_q      <= next_idx;
            ram_a_q    <= {base_q, next_idx[1:0]};
            ram_dout_q <= data_q[{next_idx[1:0], 3'b000} +: 8];
            ram_wr_q   <= 1'b1;
          end
`else
          if (cnt_q == 3'd3) begin
            state_q <= DONE;
            ready_q <= 1'b1;
          end else begin
            cnt_q      <= cnt_q + 3'd1;
            ram_a_q    <= {base_q, nidx};
            ram_dout_q <= data_q[{nidx, 3'b000} +: 8];
            ram_wr_q   <= sel_q[nidx];
          end
`endif
        end

        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_data_o  = req_data_q;
  assign req_ready_o = ready_q;
  assign busy_o      = (state_q != IDLE);
  assign ram_a_o     = ram_a_q;
  assign ram_wr_o    = ram_wr_q;
  assign ram_dout_o  = ram_dout_q;

endmodule

// File: tb/tb_ram_byte_ctrl.sv
// Self-checking bench for ram_byte_ctrl: an external byte RAM, a
// transaction-level expectation model and a per-cycle compare process.
module tb_ram_byte_ctrl;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   req_addr;
  logic          req_we;
  logic [3:0]    req_sel;
  logic [31:0]   req_data;
  logic          req_ce;
  logic [31:0]   req_data_o;
  logic          req_ready_o;
  logic          busy_o;
  logic [AW-1:0] ram_a_o;
  logic          ram_wr_o;
  logic [7:0]    ram_dout_o;
  logic [7:0]    ram_din;

  always #5 clk = ~clk;

  ram_byte_ctrl #(.RAM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_addr_i(req_addr), .req_we_i(req_we), .req_sel_i(req_sel),
    .req_data_i(req_data), .req_ce_i(req_ce),
    .req_data_o(req_data_o), .req_ready_o(req_ready_o), .busy_o(busy_o),
    .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o),
    .ram_din_i(ram_din)
  );

  // External synchronous byte RAM with a bench preload port.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_a;
  logic [7:0]    pl_d;
  always @(posedge clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    else if (ram_wr_o) mem[ram_a_o] <= ram_dout_o;
    ram_din <= mem[ram_a_o];
  end

  int cyc = 0;
  bit rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  // Reference model state.
  logic [7:0]    shadow [0:1023];
  logic [AW-1:0] exp_a  [int];
  logic [7:0]    exp_d  [int];
  bit            exp_w  [int];
  bit            exp_rdy[int];
  logic [31:0]   exp_rd [int];
  int            busy_from = 1, busy_to = 0;
  logic [AW-1:0] last_a = '0;
  logic [7:0]    last_d = '0;
  logic [31:0]   last_rd = '0;
  bit            chk_en = 1'b0;
  int            n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst_seen) begin
        last_a  = '0;
        last_d  = '0;
        last_rd = '0;
      end else begin
        if (exp_a.exists(cyc))  last_a  = exp_a[cyc];
        if (exp_d.exists(cyc))  last_d  = exp_d[cyc];
        if (exp_rd.exists(cyc)) last_rd = exp_rd[cyc];
      end
      check("ready",    {31'd0, req_ready_o}, {31'd0, !rst_seen && exp_rdy.exists(cyc)});
      check("ram_wr",   {31'd0, ram_wr_o},    {31'd0, !rst_seen && exp_w.exists(cyc)});
      check("ram_a",    32'(ram_a_o),    32'(last_a));
      check("ram_dout", 32'(ram_dout_o), 32'(last_d));
      check("req_data", req_data_o, last_rd);
      check("busy", {31'd0, busy_o},
            {31'd0, !rst_seen && cyc >= busy_from && cyc <= busy_to});
    end
  end

  // Expected behaviour of one request accepted in the current cycle k.
  task automatic plan(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                      input logic [31:0] data, output int rc);
    int k = cyc;
    int base = int'(addr & 32'h0001_FFFC);
    int t;
    logic [31:0] w;
    busy_from = k + 1;
    if (!we) begin
      for (int j = 0; j < 4; j++) exp_a[k+1+j] = AW'(base + j);
      w = {shadow[base+3], shadow[base+2], shadow[base+1], shadow[base]};
      rc = k + 6;
      exp_rd[rc] = w;
    end else begin
`ifdef RAM_BYTE_CTRL_WRITE_SKIP_EN
      t = 0;
      for (int j = 0; j < 4; j++) begin
        if (sel[j]) begin
          exp_a[k+1+t] = AW'(base + j);
          exp_d[k+1+t] = data[8*j +: 8];
          exp_w[k+1+t] = 1'b1;
          shadow[base+j] = data[8*j +: 8];
          t++;
        end
      end
      rc = k + 1 + t;
`else
      t = 0;
      for (int j = 0; j < 4; j++) begin
        exp_a[k+1+j] = AW'(base + j);
        exp_d[k+1+j] = data[8*j +: 8];
        if (sel[j]) begin
          exp_w[k+1+j] = 1'b1;
          shadow[base+j] = data[8*j +: 8];
        end
      end
      rc = k + 5 + t;
`endif
    end
    exp_rdy[rc] = 1'b1;
    busy_to = rc;
  endtask

  // mode 0: hold inputs; 1: scramble inputs mid-operation;
  // 2: move address to 0x300 and drop ce at cnt=1.
  task automatic do_req(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                        input logic [31:0] data, input int mode,
                        output logic [31:0] rd, output int lat);
    int k = cyc;
    int rc;
    lat = -1;
    plan(addr, we, sel, data, rc);
    req_addr = addr; req_we = we; req_sel = sel; req_data = data; req_ce = 1'b1;
    for (int i = 0; i < rc - k; i++) begin
      @(posedge clk); #1;
      if (req_ready_o && lat < 0) lat = cyc - k;
      if (cyc == rc) req_ce = 1'b0;
      else if (mode == 1) begin
        req_addr = $urandom; req_we = 1'($urandom); req_sel = 4'($urandom);
        req_data = $urandom; req_ce = 1'($urandom);
      end else if (mode == 2 && cyc == k + 2) begin
        req_addr = 32'h300; req_ce = 1'b0;
      end
    end
    rd = req_data_o;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, k, rc;
    logic we;
    logic [3:0] sel;
    rst = 1'b1; req_ce = 1'b0; req_addr = '0; req_we = 1'b0; req_sel = '0; req_data = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    pl_we = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      pl_a = AW'(i);
      if (i >= 256 && i < 260) pl_d = 8'(8'h11 * (i - 255));
      else pl_d = 8'($urandom);
      shadow[i] = pl_d;
      @(posedge clk); #1;
    end
    pl_we = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", {31'd0, req_ready_o}, 32'd0);
    check("reset_busy",  {31'd0, busy_o}, 32'd0);
    check("reset_wr",    {31'd0, ram_wr_o}, 32'd0);
    check("reset_a",     32'(ram_a_o), 32'd0);
    check("reset_rdata", req_data_o, 32'd0);

    do_req(32'h102, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    check("read_100_data", rd, 32'h44332211);
    check("read_latency", 32'(lat), 32'd6);

    do_req(32'h200, 1'b1, 4'b1111, 32'hAABBCCDD, 0, rd, lat);
    check("write_full_latency", 32'(lat), 32'd5);
    do_req(32'h200, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    check("readback_full", rd, 32'hAABBCCDD);

    do_req(32'h200, 1'b1, 4'b0101, 32'h12345678, 0, rd, lat);
`ifdef RAM_BYTE_CTRL_WRITE_SKIP_EN
    check("write_0101_latency", 32'(lat), 32'd3);
`else
    check("write_0101_latency", 32'(lat), 32'd5);
`endif
    do_req(32'h200, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    check("readback_partial", rd, 32'hAA34CC78);

    do_req(32'h100, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    @(posedge clk); #1;
    do_req(32'h100, 1'b1, 4'b0000, 32'hDEADBEEF, 0, rd, lat);
    check("sel0_keeps_rdata", rd, 32'h44332211);

    do_req(32'h100, 1'b0, 4'h0, 32'h0, 2, rd, lat);
    check("addr_change_ignored", rd, 32'h44332211);

    // Reset asserted while the read is at cnt=2.
    k = cyc;
    plan(32'h100, 1'b0, 4'h0, 32'h0, rc);
    req_addr = 32'h100; req_we = 1'b0; req_ce = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; req_ce = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.delete(); exp_d.delete(); exp_w.delete(); exp_rdy.delete(); exp_rd.delete();
    busy_from = 1; busy_to = 0;
    check("midrst_ready", {31'd0, req_ready_o}, 32'd0);
    check("midrst_busy",  {31'd0, busy_o}, 32'd0);
    check("midrst_a",     32'(ram_a_o), 32'd0);
    check("midrst_rdata", req_data_o, 32'd0);
    do_req(32'h100, 1'b0, 4'h0, 32'h0, 0, rd, lat);
    check("after_rst_read", rd, 32'h44332211);

    for (int n = 0; n < 300; n++) begin
      we  = 1'($urandom);
      sel = 4'($urandom);
      do_req($urandom & 32'hFFFE_03FF, we, sel, $urandom, int'($urandom_range(0, 1)), rd, lat);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
